// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared constants, state type and ID-width helper for the adder scheduler
package adder_sched_pkg;
   localparam int ADDER_W = 30;
   typedef enum logic {IDLE, LOCK} state_e;
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/adder.sv
// adder: 30-bit Kogge-Stone prefix adder with carry-in folded into bit 0's generate
module adder (
   output logic [29:0] sum,
   output logic        cout,
   input  logic [29:0] a,
   input  logic [29:0] b,
   input  logic        cin
);
   logic [29:0] pi, g, p;
   assign pi = a ^ b;
   // descending index keeps each level reading the previous level's values
   always_comb begin
      g = a & b;
      p = pi;
      g[0] = g[0] | (pi[0] & cin);
      for (int l = 0; l < 5; l++)
         for (int i = 29; i >= (1 << l); i--) begin
            g[i] = g[i] | (p[i] & g[i - (1 << l)]);
            p[i] = p[i] & p[i - (1 << l)];
         end
   end
   assign sum  = pi ^ {g[28:0], cin};
   assign cout = g[29];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting the search at ptr (rotate, priority pick, rotate back)
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   input  logic           en,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx
);
   logic [N-1:0]   rot;
   logic [IDW-1:0] first;
   logic [IDW:0]   pos;
   logic           any;
   always_comb begin
      rot   = N'({req, req} >> ptr);
      first = '0;
      any   = 1'b0;
      for (int i = N - 1; i >= 0; i--)
         if (rot[i]) begin
            first = IDW'(i);
            any   = 1'b1;
         end
      pos = {1'b0, first} + {1'b0, ptr};
      idx = (pos >= (IDW + 1)'(N)) ? IDW'(pos - (IDW + 1)'(N)) : pos[IDW-1:0];
      gnt = (en && any) ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: shares one adder among NREQ requesters, round-robin with lockable carry chains
module adder_rr_sched
   import adder_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = id_w(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*ADDER_W-1:0] req_a,
   input  logic [NREQ*ADDER_W-1:0] req_b,
   input  logic [NREQ-1:0]         req_cin,
   input  logic [NREQ-1:0]         req_chain,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ADDER_W-1:0]      rsp_sum,
   output logic                    rsp_cout,
   output logic [IDW-1:0]          rsp_id,
   output logic                    rsp_last
);
   state_e             state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d, owner_q, owner_d, id_q, id_d;
   logic               carry_q, carry_d, rsp_valid_q, rsp_valid_d;
   logic               cout_q, cout_d, last_q, last_d;
   logic [ADDER_W-1:0] sum_q, sum_d;
   logic               slot_free, lock, fire, add_cin, add_cout;
   logic [NREQ-1:0]    arb_gnt, lock_rdy;
   logic [IDW-1:0]     arb_idx, g;
   logic [ADDER_W-1:0] op_a, op_b, add_sum;

   assign lock      = (state_q == LOCK);
   assign slot_free = ~rsp_valid_q | rsp_ready;
   assign g         = lock ? owner_q : arb_idx;
   assign lock_rdy  = NREQ'(slot_free & req_valid[owner_q]) << owner_q;
   assign req_ready = rst ? '0 : (lock ? lock_rdy : (arb_gnt & {NREQ{slot_free}}));
   assign fire      = |(req_valid & req_ready);
   assign op_a      = req_a[int'(g) * ADDER_W +: ADDER_W];
   assign op_b      = req_b[int'(g) * ADDER_W +: ADDER_W];
   // a locked chain continues from the previous word's carry, not the requester's cin
   assign add_cin   = lock ? carry_q : req_cin[g];

   rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
      .req(req_valid), .ptr(ptr_q), .en(~lock), .gnt(arb_gnt), .idx(arb_idx)
   );

   adder u_adder (.sum(add_sum), .cout(add_cout), .a(op_a), .b(op_b), .cin(add_cin));

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      carry_d     = carry_q;
      rsp_valid_d = rsp_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      id_d        = id_q;
      last_d      = last_q;
      if (fire) begin
         rsp_valid_d = 1'b1;
         sum_d       = add_sum;
         cout_d      = add_cout;
         id_d        = g;
         last_d      = ~req_chain[g];
         carry_d     = add_cout;
         state_d     = req_chain[g] ? LOCK : IDLE;
         owner_d     = req_chain[g] ? g : owner_q;
         ptr_d       = req_chain[g] ? ptr_q : ((g == IDW'(NREQ - 1)) ? '0 : g + 1'b1);
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         carry_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         id_q        <= '0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         carry_q     <= carry_d;
         rsp_valid_q <= rsp_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         id_q        <= id_d;
         last_q      <= last_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign rsp_id    = id_q;
   assign rsp_last  = last_q;
endmodule
